// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES types, S-box, GF(2^8) helpers and FSM state encodings.
// Rev     : 1.0
// ============================================================================

// Byte i of a 128-bit block; byte 0 is the most significant byte.
`define AES_BYTE(blk, i) blk[127-8*(i) -: 8]

package aes_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } aes_fsm_e;

    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic int NR(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return C_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_cipher_core_if.sv
`default_nettype none
// ============================================================================
// Module  : aes_cipher_core_if
// Brief   : Plaintext-in / ciphertext-out valid-ready stream bundle.
// Rev     : 1.0
// ============================================================================
interface aes_cipher_core_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_block_t in_block;
    logic       out_valid;
    logic       out_ready;
    aes_block_t out_block;

    modport master (
        output in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

`default_nettype wire

// File: rtl/aes_round.sv
`default_nettype none
// ============================================================================
// Module  : aes_round
// Brief   : One combinational AES round; last=1 omits MixColumns.
// Rev     : 1.0
// ============================================================================
module aes_round
    import aes_pkg::*;
(
    input  wire logic [127:0] state,
    input  wire logic [127:0] rk,
    input  wire logic         last,
    output logic      [127:0] next
);

    logic [7:0] w_sb [16];
    logic [7:0] w_sr [16];
    logic [7:0] w_mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_sb[i] = sbox(`AES_BYTE(state, i));
        end
        // Column-major order: row r of column c sits at byte r + 4*c.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[r + 4*c] = w_sb[r + 4*((c + r) % 4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                        ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                        ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                        ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
            w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1]
                        ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
        end
        next = '0;
        for (int i = 0; i < 16; i++) begin
            `AES_BYTE(next, i) = (last ? w_sr[i] : w_mc[i]) ^ `AES_BYTE(rk, i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_cipher_core.sv
`default_nettype none
// ============================================================================
// Module  : aes_cipher_core
// Brief   : Iterative AES encryption core, one round per clock, valid/ready I/O.
// Rev     : 1.0
// ============================================================================
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int NK = 4
)(
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [128*(NK+7)-1:0] round_keys,
    input  wire logic                  keys_valid,
    output logic                       busy,
    aes_cipher_core_if.slave           bus
);

    localparam int         C_NR         = NR(NK);
    localparam int         C_RKW        = 128*(NK+7);
    localparam logic [3:0] C_LAST_ROUND = 4'(C_NR - 1);

    aes_fsm_e     r_state;
    logic [3:0]   r_round_cnt;
    logic [127:0] r_state_reg;
    logic [127:0] r_out_block;
    logic         r_out_valid;

    logic [127:0] w_rk;
    logic [127:0] w_next;
    logic         w_in_ready;

    // round_cnt is 0 in IDLE and Nr in FINAL, so one select serves every phase.
    assign w_rk       = round_keys[C_RKW - 1 - 128*int'(r_round_cnt) -: 128];
    assign w_in_ready = (r_state == ST_IDLE) && keys_valid && !reset;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_block = r_out_block;
    assign busy          = (r_state == ST_ROUND) || (r_state == ST_FINAL);

    aes_round u_round (
        .state (r_state_reg),
        .rk    (w_rk),
        .last  (r_state == ST_FINAL),
        .next  (w_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_round_cnt <= 4'd0;
            r_state_reg <= '0;
            r_out_block <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && w_in_ready) begin
                        r_state_reg <= bus.in_block ^ w_rk;
                        r_round_cnt <= 4'd1;
                        r_state     <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_state_reg <= w_next;
                    r_round_cnt <= r_round_cnt + 4'd1;
                    if (r_round_cnt == C_LAST_ROUND) begin
                        r_state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    r_out_block <= w_next;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_round_cnt <= 4'd0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
